adc_scan: RTL and testbench
===========================

# adc_scan

Parametrised scanning controller for the LTC2308 SPI ADC on the DE0-Nano. It replaces the fixed 8-channel wrapper with a design that has a configurable channel count, SPI clock divider, conversion time and optional per-channel averaging. It drives the ADC pins directly from `sys_clk`, with no separate SPI clock. It publishes zero-extended 32-bit results on the packed `adc_channels` bus, which feeds the Avalon register slave, together with per-scan completion strobes.

## Interface
- `NUM_CH`, 8: channels scanned, 1..8, in round-robin order 0..NUM_CH-1.
- `CLK_DIV`, 2: `sys_clk` cycles per SCK half-period, ≥1.
- `CONV_CYCLES`, 80: `sys_clk` cycles that CONVST is held high (1.6 µs at 50 MHz), ≥2.
- `AVG_LOG2`, 2: log2 of the number of samples averaged per channel, 0..4 (used only with `ADC_SCAN_AVG_EN`).

Ports (one clock; reset is asynchronous and active-low):
- `sys_clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  level; run scanning while high.
- `adc_channels`  out  NUM_CH*32  channel i occupies bits [i*32+31:i*32], formatted {20'd0, 12-bit result}.
- `sample_valid`  out  1  one-cycle pulse when any channel word updates.
- `sample_ch`  out  3  index of the channel updated; valid with `sample_valid`.
- `scan_done`  out  1  one-cycle pulse when channel NUM_CH-1 word updates.
- `ADC_CONVST`  out  1  conversion start.
- `ADC_SCK`  out  1  SPI clock, idle low.
- `ADC_SDI`  out  1  configuration word to the ADC, MSB first.
- `ADC_SDO`  in  1  conversion result from the ADC, MSB first.

## Operation
- FSM states: IDLE, CONV, SHIFT, COMMIT.
- IDLE:
  - All ADC pins are held low.
  - When `enable` is high, go to CONV with `prime`=1.
- CONV:
  - CONVST is high for CONV_CYCLES cycles, then low.
  - Then go to SHIFT.
- SHIFT: 12 SCK periods.
  - SDI presents cfg = {1, ch[0], ch[2], ch[1], 1, 0}, padded with six 0s. It changes only while SCK is low.
  - SDO is sampled on the `sys_clk` edge that raises SCK.
- Pipeline:
  - Each frame sends cfg for channel `c_send` and receives the result of the previous frame's `c_send`, tracked in `c_rx`.
  - `c_send` increments modulo NUM_CH after every frame.
- COMMIT (1 cycle):
  - If `prime`, discard the shifted data and clear `prime`.
  - Otherwise deliver the 12-bit result for `c_rx`.
  - Then go to CONV if `enable` is high, else IDLE.
- `enable` dropping mid-frame: the current frame completes, including COMMIT, then the FSM enters IDLE. Re-enabling starts a new priming frame.
- Delivery without averaging:
  - The `c_rx` word is written with the result.
  - `sample_valid` pulses and `sample_ch` = `c_rx`.
  - `scan_done` pulses if `c_rx` = NUM_CH-1.
- Unused channel bits above 12 are always 0. NUM_CH=1 scans channel 0 every frame.

## Timing
- Reset value of every output is 0, including `adc_channels`, all strobes and all pins. This holds immediately on asynchronous reset, including mid-frame.
- Frame length is CONV_CYCLES + 24*CLK_DIV + 1 cycles; with defaults this is 129 cycles.
- First update after enable lands at the end of frame 2, 258 cycles with defaults.
- Output words and strobes change in the cycle after COMMIT and are registered.
- SCK duty is 50%. The first SCK rising edge is CLK_DIV cycles after SHIFT entry, with SDI bit 11 stable at SHIFT entry.

## Configuration
- `ADC_SCAN_AVG_EN` defined:
  - Each channel has an accumulator of width 12+AVG_LOG2 and a sample counter.
  - After 2^AVG_LOG2 deliveries, the word is written as acc >> AVG_LOG2 (truncating), the accumulator is cleared, and `sample_valid`/`scan_done` fire.
  - Intermediate deliveries produce no strobes.
  - Accumulators and counters clear on reset and on every IDLE→CONV transition.
- `ADC_SCAN_AVG_EN` not defined: no accumulators are built, every delivery writes directly, and AVG_LOG2 is ignored.

## Structure
- Package `adc_pkg` holds:
  - `ADC_RES`=12 and `ADC_WORD_W`=32.
  - The FSM state enum.
  - The function `adc_cfg_word(ch)` that returns the 6-bit config.
- Sub-module `adc_spi_frame` does one frame of SCK generation and SDI/SDO shifting, with a start/done handshake. `adc_scan` owns the CONV timing, channel bookkeeping, averaging and outputs.

## Test plan
- Reset and idle: reset mid-SHIFT → all outputs 0 next cycle. With `enable`=0, the pins stay low for 1000 cycles.
- Single scan with defaults and no averaging:
  - Stimulus: an ADC model returns 0x100+ch.
  - Required: after priming, words 0..7 read 0x00000100..0x00000107.
  - Required: `scan_done` pulses once per 8 `sample_valid`.
  - Required: SDI cfg for ch5 is 6'b111010.
- Pipeline alignment: with the model returning 0xFFF for ch3 only, only `adc_channels[127:96]` = 0x00000FFF and the first frame's data is never written.
- NUM_CH=3, CLK_DIV=1, CONV_CYCLES=4:
  - Frame length is 29 cycles.
  - Channel order is 0,1,2,0.
  - Words above bit 95 do not exist.
- Averaging with the macro defined and AVG_LOG2=2:
  - Stimulus: ch0 samples 10, 11, 12, 14.
  - Required: one strobe and word = 11.
  - Required: re-enabling mid-average discards the partial sum.
- Enable drop mid-SHIFT: the frame completes, COMMIT updates the word, then IDLE. Re-enabling gives the first update after 2 frames.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and LTC2308 config-word helper for the adc_scan slice.
package adc_pkg;
  localparam int ADC_RES    = 12;
  localparam int ADC_WORD_W = 32;

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, COMMIT} adc_state_e;

  // LTC2308 DIN word: single-ended, odd/sign + select bits, unipolar, no sleep
  function automatic logic [5:0] adc_cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction
endpackage

// File: rtl/adc_scan_if.sv
// Result bus from adc_scan to the register slave: packed channel words plus update strobes.
interface adc_scan_if #(parameter int NUM_CH = 8);
  import adc_pkg::*;
  logic [NUM_CH*ADC_WORD_W-1:0] adc_channels;
  logic                         sample_valid;
  logic [2:0]                   sample_ch;
  logic                         scan_done;

  modport master (output adc_channels, sample_valid, sample_ch, scan_done);
  modport slave  (input  adc_channels, sample_valid, sample_ch, scan_done);
endinterface

// File: rtl/adc_spi_frame.sv
// One LTC2308 SPI frame: 12 SCK periods, SDI shifted out MSB first, SDO captured on SCK rise.
module adc_spi_frame import adc_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [5:0]         cfg,
  output logic               done,
  output logic [ADC_RES-1:0] rx_data,
  output logic               sck,
  output logic               sdi,
  input  logic               sdo
);
  localparam int DW = $clog2(CLK_DIV + 1);

  logic               busy;
  logic [DW-1:0]      div_cnt;
  logic [3:0]         bit_cnt;
  logic [ADC_RES-1:0] tx_sr;
  logic               tick;

  assign tick = busy && (div_cnt == DW'(CLK_DIV - 1));
  // Combinational so the caller leaves SHIFT on the same edge as the final SCK fall
  assign done = tick && sck && (bit_cnt == 4'd11);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_data <= '0;
      sck     <= 1'b0;
      sdi     <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      tx_sr   <= {cfg, 6'b0};
      sdi     <= cfg[5];
    end else if (busy) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        sck <= ~sck;
        if (!sck) begin
          rx_data <= {rx_data[ADC_RES-2:0], sdo};
        end else begin
          // SDI only moves on the falling edge; the padding drives it back to 0 at the end
          tx_sr   <= {tx_sr[ADC_RES-2:0], 1'b0};
          sdi     <= tx_sr[ADC_RES-2];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd11) busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/adc_scan.sv
// LTC2308 round-robin scanner: CONVST timing, pipelined channel bookkeeping, result words.
// Optional per-channel averaging is built when ADC_SCAN_AVG_EN is defined.
module adc_scan import adc_pkg::*; #(
  parameter int NUM_CH      = 8,
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int AVG_LOG2    = 2
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       enable,
  adc_scan_if.master res,
  output logic       ADC_CONVST,
  output logic       ADC_SCK,
  output logic       ADC_SDI,
  input  logic       ADC_SDO
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = $clog2(CONV_CYCLES);

  if (NUM_CH < 1 || NUM_CH > 8 || CLK_DIV < 1 || CONV_CYCLES < 2 ||
      AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_param_chk
    $error("adc_scan: parameter out of range");
  end

  adc_state_e               state, state_nx;
  logic [CW-1:0]            conv_cnt;
  logic                     prime;
  logic [CHW-1:0]           c_send, c_rx;
  logic                     spi_start, spi_done;
  logic [ADC_RES-1:0]       rx_data;
  logic                     deliver, wr_en;
  logic [ADC_RES-1:0]       wr_data;
  logic [NUM_CH-1:0][ADC_RES-1:0] words;
  logic                     sv_q, sd_q;
  logic [2:0]               sch_q;

  always_comb begin
    state_nx  = state;
    spi_start = 1'b0;
    case (state)
      IDLE:   if (enable) state_nx = CONV;
      CONV:   if (conv_cnt == CW'(CONV_CYCLES - 1)) begin
                state_nx  = SHIFT;
                spi_start = 1'b1;
              end
      SHIFT:  if (spi_done) state_nx = COMMIT;
      COMMIT: state_nx = enable ? CONV : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      conv_cnt <= '0;
      prime    <= 1'b0;
      c_send   <= '0;
      c_rx     <= '0;
    end else begin
      state    <= state_nx;
      conv_cnt <= (state == CONV) ? conv_cnt + 1'b1 : '0;
      if (state == IDLE && enable) prime <= 1'b1;
      // Each frame returns the conversion configured by the frame before it
      if (state == COMMIT) begin
        prime  <= 1'b0;
        c_rx   <= c_send;
        c_send <= (c_send == CHW'(NUM_CH - 1)) ? '0 : c_send + 1'b1;
      end
    end
  end

  adc_spi_frame #(.CLK_DIV(CLK_DIV)) u_spi (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .start   (spi_start),
    .cfg     (adc_cfg_word(3'(c_send))),
    .done    (spi_done),
    .rx_data (rx_data),
    .sck     (ADC_SCK),
    .sdi     (ADC_SDI),
    .sdo     (ADC_SDO)
  );

  assign ADC_CONVST = (state == CONV);
  assign deliver    = (state == COMMIT) && !prime;

`ifdef ADC_SCAN_AVG_EN
  localparam int AW = ADC_RES + AVG_LOG2;
  localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [NUM_CH-1:0][AW-1:0] acc;
  logic [NUM_CH-1:0][NW-1:0] cnt;
  logic [AW-1:0]             sum;

  assign sum     = acc[c_rx] + AW'(rx_data);
  assign wr_en   = deliver && (cnt[c_rx] == NW'((1 << AVG_LOG2) - 1));
  assign wr_data = ADC_RES'(sum >> AVG_LOG2);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE && enable) begin
      // A restart never mixes samples from before the pause into a new average
      acc <= '0;
      cnt <= '0;
    end else if (deliver) begin
      acc[c_rx] <= wr_en ? '0 : sum;
      cnt[c_rx] <= wr_en ? '0 : cnt[c_rx] + 1'b1;
    end
  end
`else
  assign wr_en   = deliver;
  assign wr_data = rx_data;
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      words <= '0;
      sv_q  <= 1'b0;
      sd_q  <= 1'b0;
      sch_q <= '0;
    end else begin
      sv_q <= wr_en;
      sd_q <= wr_en && (c_rx == CHW'(NUM_CH - 1));
      if (wr_en) begin
        words[c_rx] <= wr_data;
        sch_q       <= 3'(c_rx);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign res.adc_channels[i*ADC_WORD_W +: ADC_WORD_W] =
      {{(ADC_WORD_W - ADC_RES){1'b0}}, words[i]};
  end

  assign res.sample_valid = sv_q;
  assign res.sample_ch    = sch_q;
  assign res.scan_done    = sd_q;
endmodule

// File: tb/tb_adc_scan.sv
// Scoreboard bench for adc_scan: default config, a 3-channel fast config and, with
// ADC_SCAN_AVG_EN, a 1-channel averaging config, each driven by a behavioural LTC2308.
module tb_adc_scan;
  typedef struct packed {logic [2:0] ch; logic [11:0] val;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;

  adc_scan_if #(.NUM_CH(8)) ifa ();
  adc_scan_if #(.NUM_CH(3)) ifb ();
  logic cv_a, sck_a, sdi_a, sdo_a = 1'b0;
  logic cv_b, sck_b, sdi_b, sdo_b = 1'b0;

  adc_scan #(.NUM_CH(8), .CLK_DIV(2), .CONV_CYCLES(80), .AVG_LOG2(0)) dut_a (
    .sys_clk(clk), .reset_n(rst_n), .enable(en_a), .res(ifa.master),
    .ADC_CONVST(cv_a), .ADC_SCK(sck_a), .ADC_SDI(sdi_a), .ADC_SDO(sdo_a));
  adc_scan #(.NUM_CH(3), .CLK_DIV(1), .CONV_CYCLES(4), .AVG_LOG2(0)) dut_b (
    .sys_clk(clk), .reset_n(rst_n), .enable(en_b), .res(ifb.master),
    .ADC_CONVST(cv_b), .ADC_SCK(sck_b), .ADC_SDI(sdi_b), .ADC_SDO(sdo_b));

  logic [2:0] sv;
  assign sv[0] = ifa.sample_valid;
  assign sv[1] = ifb.sample_valid;

  function automatic logic [2:0] dec(input logic [5:0] c);
    return {c[3], c[2], c[4]};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm, input logic [2:0] ch);
    n_vec++; n_err++;
    $display("FAIL %s: unexpected strobe ch %0d, want none", nm, ch);
  endtask

  task automatic sample_chk(input string nm, input exp_t e, input logic v, input logic [2:0] ch,
                            input logic [31:0] word, input logic done, input int last);
    chk({nm, "_valid"}, v, 1'b1);
    chk({nm, "_ch"}, ch, e.ch);
    chk({nm, "_word"}, word, {20'd0, e.val});
    chk({nm, "_done"}, done, (32'(e.ch) == last));
  endtask

  task automatic wait_sv(input int d, input int lim, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!sv[d] && cyc < lim);
    if (!sv[d]) begin
      n_vec++; n_err++;
      $display("FAIL timeout_dut%0d: no sample_valid within %0d cycles", d, lim);
    end
  endtask

  // ---- LTC2308 models: config from frame k selects the conversion read in frame k+1
  logic [11:0] sr_a = '0, res_a = '0; int nb_a = 0, bi_a = 0, mode_a = 0;
  logic [2:0]  last_a = 3'd3;
  logic [11:0] log_a[$];
  always @(posedge sck_a) begin sr_a = {sr_a[10:0], sdi_a}; nb_a++; end
  always @(posedge cv_a) begin
    if (nb_a == 12) begin log_a.push_back(sr_a); last_a = dec(sr_a[11:6]); end
    nb_a = 0;
    res_a = (mode_a == 0) ? 12'h100 + 12'(last_a) : ((last_a == 3'd3) ? 12'hFFF : 12'h000);
  end
  always @(negedge cv_a) begin bi_a = 11; sdo_a = res_a[11]; end
  always @(negedge sck_a) begin bi_a--; sdo_a = (bi_a >= 0) ? res_a[bi_a] : 1'b0; end

  logic [11:0] sr_b = '0, res_b = '0; int nb_b = 0, bi_b = 0;
  logic [2:0]  last_b = 3'd0;
  always @(posedge sck_b) begin sr_b = {sr_b[10:0], sdi_b}; nb_b++; end
  always @(posedge cv_b) begin
    if (nb_b == 12) last_b = dec(sr_b[11:6]);
    nb_b = 0;
    res_b = 12'h2A0 + 12'(last_b);
  end
  always @(negedge cv_b) begin bi_b = 11; sdo_b = res_b[11]; end
  always @(negedge sck_b) begin bi_b--; sdo_b = (bi_b >= 0) ? res_b[bi_b] : 1'b0; end

`ifdef ADC_SCAN_AVG_EN
  adc_scan_if #(.NUM_CH(1)) ifc ();
  logic en_c = 1'b0;
  logic cv_c, sck_c, sdi_c, sdo_c = 1'b0;
  adc_scan #(.NUM_CH(1), .CLK_DIV(1), .CONV_CYCLES(4), .AVG_LOG2(2)) dut_c (
    .sys_clk(clk), .reset_n(rst_n), .enable(en_c), .res(ifc.master),
    .ADC_CONVST(cv_c), .ADC_SCK(sck_c), .ADC_SDI(sdi_c), .ADC_SDO(sdo_c));
  assign sv[2] = ifc.sample_valid;

  // Conversion sequence: prime, 10/11/12/14, partial 100s, prime, 20/20/20/24
  logic [11:0] seq_c [16] = '{12'd500, 12'd10, 12'd11, 12'd12, 12'd14, 12'd100, 12'd100,
                              12'd100, 12'd777, 12'd20, 12'd20, 12'd20, 12'd24, 12'd0,
                              12'd0, 12'd0};
  logic [11:0] res_c = '0; int ci_c = 0, bi_c = 0;
  always @(posedge cv_c) begin res_c = seq_c[ci_c & 15]; ci_c++; end
  always @(negedge cv_c) begin bi_c = 11; sdo_c = res_c[11]; end
  always @(negedge sck_c) begin bi_c--; sdo_c = (bi_c >= 0) ? res_c[bi_c] : 1'b0; end

  always @(negedge clk) if (rst_n && (ifc.sample_valid || ifc.scan_done)) begin
    if (qc.size() == 0) extra("c_sample", ifc.sample_ch);
    else begin
      ec = qc.pop_front();
      sample_chk("c", ec, ifc.sample_valid, ifc.sample_ch, ifc.adc_channels[31:0],
                 ifc.scan_done, 0);
    end
  end
`else
  assign sv[2] = 1'b0;
`endif

  // ---- scoreboard monitors
  always @(negedge clk) if (rst_n && (ifa.sample_valid || ifa.scan_done)) begin
    if (qa.size() == 0) extra("a_sample", ifa.sample_ch);
    else begin
      ea = qa.pop_front();
      sample_chk("a", ea, ifa.sample_valid, ifa.sample_ch, ifa.adc_channels[ea.ch*32 +: 32],
                 ifa.scan_done, 7);
    end
  end

  always @(negedge clk) if (rst_n && (ifb.sample_valid || ifb.scan_done)) begin
    if (qb.size() == 0) extra("b_sample", ifb.sample_ch);
    else begin
      eb = qb.pop_front();
      sample_chk("b", eb, ifb.sample_valid, ifb.sample_ch, ifb.adc_channels[eb.ch*32 +: 32],
                 ifb.scan_done, 2);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---- stimulus
  initial begin
    int c;
    logic bad;
    logic [2:0] cc;
    logic [255:0] exp_bus;

    repeat (3) @(negedge clk);
    chk("rst_bus_a", ifa.adc_channels, '0);
    chk("rst_strb_a", {ifa.sample_valid, ifa.scan_done, ifa.sample_ch}, '0);
    chk("rst_pins_a", {cv_a, sck_a, sdi_a}, '0);
    chk("rst_bus_b", ifb.adc_channels, '0);
    rst_n = 1'b1;

    bad = 1'b0;
    repeat (1000) begin @(negedge clk); if ({cv_a, sck_a, sdi_a} != 3'b0) bad = 1'b1; end
    chk("idle_pins_a", bad, 1'b0);

    // Default scan: model returns 0x100+ch
    for (int i = 0; i < 8; i++) qa.push_back('{ch: 3'(i), val: 12'h100 + 12'(i)});
    en_a = 1'b1;
    wait_sv(0, 400, c);
    chk("a_first_latency", c, 2*129 + 1);   // +1 for the IDLE->CONV edge
    wait_sv(0, 400, c);
    chk("a_frame_len", c, 129);
    for (int i = 2; i < 8; i++) wait_sv(0, 400, c);
    for (int i = 0; i < 8; i++)
      chk($sformatf("a_word%0d", i), ifa.adc_channels[i*32 +: 32], 32'h100 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      cc = 3'(i);
      chk($sformatf("a_cfg_frame%0d", i), log_a[i], {1'b1, cc[0], cc[2], cc[1], 2'b10, 6'b0});
    end
    chk("a_cfg_ch5", log_a[5], 12'b111010_000000);

    // Drop enable mid-SHIFT: the frame finishes and delivers channel 0 again
    repeat (100) @(negedge clk);
    qa.push_back('{ch: 3'd0, val: 12'h100});
    en_a = 1'b0;
    wait_sv(0, 200, c);
    chk("a_drop_commit", c, 29);
    bad = 1'b0;
    repeat (200) begin @(negedge clk); if (cv_a) bad = 1'b1; end
    chk("a_idle_after_drop", bad, 1'b0);

    // Re-enable: new priming frame; c_send continues at 2
    qa.push_back('{ch: 3'd2, val: 12'h102});
    en_a = 1'b1;
    wait_sv(0, 400, c);
    chk("a_reenable_latency", c, 2*129 + 1);

    // Asynchronous reset in the middle of SHIFT
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_bus", ifa.adc_channels, '0);
    chk("midreset_strb", {ifa.sample_valid, ifa.scan_done, ifa.sample_ch}, '0);
    chk("midreset_pins", {cv_a, sck_a, sdi_a}, '0);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Pipeline alignment: only channel 3 reads full scale, ADC powers up on ch3
    mode_a = 1; last_a = 3'd3;
    for (int i = 0; i < 8; i++)
      qa.push_back('{ch: 3'(i), val: (i == 3) ? 12'hFFF : 12'h000});
    en_a = 1'b1;
    for (int i = 0; i < 8; i++) wait_sv(0, 400, c);
    exp_bus = '0;
    exp_bus[96 +: 32] = 32'h0000_0FFF;
    chk("a_pipe_bus", ifa.adc_channels, exp_bus);
    qa.push_back('{ch: 3'd0, val: 12'h000});
    en_a = 1'b0;
    wait_sv(0, 200, c);

    // NUM_CH=3, CLK_DIV=1, CONV_CYCLES=4
    for (int i = 0; i < 4; i++) qb.push_back('{ch: 3'(i % 3), val: 12'h2A0 + 12'(i % 3)});
    en_b = 1'b1;
    wait_sv(1, 200, c);
    chk("b_first_latency", c, 2*29 + 1);
    for (int i = 1; i < 4; i++) begin
      wait_sv(1, 200, c);
      chk($sformatf("b_frame_len%0d", i), c, 29);
    end
    qb.push_back('{ch: 3'd1, val: 12'h2A1});
    en_b = 1'b0;
    wait_sv(1, 200, c);
    chk("b_bus", ifb.adc_channels, {32'h2A2, 32'h2A1, 32'h2A0});

`ifdef ADC_SCAN_AVG_EN
    // Averaging: (10+11+12+14)>>2 = 11; later partial sum of 300 must be discarded
    qc.push_back('{ch: 3'd0, val: 12'd11});
    en_c = 1'b1;
    wait_sv(2, 400, c);
    chk("c_avg_latency", c, 5*29 + 1);
    repeat (70) @(negedge clk);
    en_c = 1'b0;
    repeat (40) @(negedge clk);
    qc.push_back('{ch: 3'd0, val: 12'd21});
    en_c = 1'b1;
    wait_sv(2, 400, c);
    chk("c_restart_latency", c, 5*29 + 1);
    en_c = 1'b0;
    repeat (60) @(negedge clk);
`endif

    repeat (50) @(negedge clk);
    chk("queues_drained", qa.size() + qb.size() + qc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
